apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
Shares one APB requester-side bus between NREQ local requesters using round-robin arbitration. Each requester presents a transfer (addr, write, wdata) with a level req. The arbiter runs the APB SETUP/ACCESS sequence to the slave and returns a one-cycle done pulse with rdata/err. It sits between the internal bus clients and the APB slaves, and replaces per-client masters.

Parameters:
NREQ, 4, number of requesters (2..16)
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables

Ports:
pclk  in  1  clock
prst  in  1  synchronous reset, active low
req  in  NREQ  per-requester transfer request, level, held until done
req_write  in  NREQ  per-requester direction, 1=write
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
gnt  out  NREQ  one-hot grant, held SETUP through RESP
done  out  NREQ  one-hot completion pulse, one cycle, in RESP
rdata  out  DW  read data of last completed read
err  out  1  error of last completed transfer (pslverr or timeout), valid with done
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  AW  APB address
pwrite  out  1  APB direction
pwdata  out  DW  APB write data
prdata  in  DW  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- All outputs are registered. Reset (prst=0 at posedge) zeroes psel, penable, paddr, pwrite, pwdata, gnt, done, rdata, err, timeout counter. State returns to IDLE and the rr pointer goes to NREQ-1, so requester 0 has first priority. Reset mid-transfer aborts it with no done.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if req != 0, pick the winner. Search starts at pointer+1 mod NREQ and takes the first set bit. Latch its addr/write/wdata into paddr/pwrite/pwdata, set gnt, psel=1, penable=0, pointer=winner, and go to SETUP. If req == 0, stay in IDLE with psel=0.
- SETUP (one cycle): set penable=1 and go to ACCESS. The timeout counter clears.
- ACCESS: psel=penable=1, and paddr/pwrite/pwdata stay stable.
  - pready=1 sampled: psel=0, penable=0, done[gnt]=1, err=pslverr. If read, rdata=prdata; if write, rdata is unchanged. Go to RESP.
  - pready=0: counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with pready still low, terminate: psel=penable=0, done[gnt]=1, err=1, rdata unchanged. Go to RESP.
- RESP (one cycle): done is high this cycle only. No arbitration here, so the requester deasserts req on the edge ending RESP. Next cycle: done=0, gnt=0, state IDLE.
- Throughput: 4 cycles per zero-wait transfer (IDLE, SETUP, ACCESS, RESP). Min latency from req to done is 3 cycles.
- A req dropped after grant is ignored; the transfer completes. Changes to a granted requester's addr/wdata after the IDLE cycle have no effect.
- Fairness: with all req high, grants rotate 0,1,2,3,0,... No requester waits more than NREQ-1 transfers.
- paddr/pwdata/pwrite retain the last values when idle. Only psel/penable qualify them.

Decomposition:
- apb_pkg: state enum (IDLE, SETUP, ACCESS, RESP), default width localparams.
- Sub-module rr_picker: combinational. Inputs are req and pointer; output is a one-hot winner and its index. It is reused by future bus arbiters.

Test Plan:
- Single read: req=4'b0001, addr0=0x10, slave pready=1 in first ACCESS with prdata=0xDEADBEEF. Expect psel high 2 cycles, penable 1 cycle, done=4'b0001 at cycle 3 after req, rdata=0xDEADBEEF, err=0.
- Round-robin: req=4'b1111 held, re-raised after each done. Expect grant order 0,1,2,3,0 and gnt never multi-hot.
- Wait states and error: write to 0x20, wdata=0x55AA, pready low 3 cycles then high with pslverr=1. Expect penable high 4 cycles, paddr/pwdata stable, err=1, rdata unchanged.
- Timeout: TIMEOUT=16, pready held low. Expect abort after 16 ACCESS cycles, done pulse, err=1, psel=0 next cycle; the next queued requester is granted afterwards.
- Reset mid-ACCESS: prst=0 during ACCESS. Expect all outputs 0 next cycle, no done. Afterwards req=4'b1000|4'b0001 grants requester 0 first.
- Late req drop: requester 2 drops req in SETUP. Expect the transfer to complete with done[2]=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared state encoding and default sizing for the APB round-robin arbiter.
package apb_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr_i, wrapping.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         win_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);
  localparam int IW = $clog2(NREQ);

  // One spare bit so ptr+k never overflows before the wrap correction.
  logic [IW:0] cand;
  logic        found;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found               = 1'b1;
        win_o[cand[IW-1:0]] = 1'b1;
        idx_o               = cand[IW-1:0];
      end
    end
  end

  assign valid_o = |req_i;
endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB requester port among NREQ local clients.
module apb_rr_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic             psel,
  output logic             penable,
  output logic [AW-1:0]    paddr,
  output logic             pwrite,
  output logic [DW-1:0]    pwdata,
  input  logic [DW-1:0]    prdata,
  input  logic             pready,
  input  logic             pslverr
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e      state_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, done_q;
  logic [DW-1:0]   rdata_q, pwdata_q;
  logic [AW-1:0]   paddr_q;
  logic            err_q, psel_q, penable_q, pwrite_q;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            timeout_hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(NREQ - 1);
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            paddr_q   <= addr_arr[win_idx];
            pwdata_q  <= wdata_arr[win_idx];
            pwrite_q  <= req_write[win_idx];
            gnt_q     <= win;
            ptr_q     <= win_idx;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= pslverr;
            if (!pwrite_q) begin
              rdata_q <= prdata;
            end
            state_q   <= S_RESP;
          end else if (timeout_hit) begin
            // Abort a hung slave; rdata keeps the last good read.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= 1'b1;
            state_q   <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              prst;
  logic [NREQ-1:0]   req, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, done;
  logic [DW-1:0]     rdata, pwdata, prdata;
  logic [AW-1:0]     paddr;
  logic              err, psel, penable, pwrite, pready, pslverr;

  int checks = 0;
  int errors = 0;
  int last_ptr;
  logic [DW-1:0] exp_rdata;
  int who;

  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last_ptr + k) % NREQ]) return (last_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    prst = 1'b0;
    req = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    prst = 1'b1;
    last_ptr = NREQ - 1;
    exp_rdata = '0;
  endtask

  task automatic run_xfer(input int waits, input bit slverr, input bit to_mode,
                          input bit drop_setup, input logic [DW-1:0] rd, output int w);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [NREQ-1:0] oh;
    logic exp_err;
    bit ew, seen;
    int lat, limit;
    w = model_pick(req);
    if (w < 0) w = 0;
    ea = req_addr[w*AW +: AW];
    ed = req_wdata[w*DW +: DW];
    ew = req_write[w];
    oh = '0;
    oh[w] = 1'b1;
    seen = 0;
    lat = 0;
    while (!seen && lat < 6) begin
      @(negedge pclk);
      lat++;
      if (psel === 1'b1) seen = 1;
    end
    chk("setup_latency", lat === 1, 64'(lat), 64'(1));
    if (!seen) return;
    chk("setup_gnt", gnt === oh, 64'(gnt), 64'(oh));
    chk("setup_onehot", $countones(gnt) === 1, 64'($countones(gnt)), 64'(1));
    chk("setup_penable", penable === 1'b0, 64'(penable), 64'(0));
    chk("setup_paddr", paddr === ea, 64'(paddr), 64'(ea));
    chk("setup_pwrite", pwrite === ew, 64'(pwrite), 64'(ew));
    chk("setup_pwdata", pwdata === ed, 64'(pwdata), 64'(ed));
    last_ptr = w;
    req_addr[w*AW +: AW] = $urandom;
    req_wdata[w*DW +: DW] = $urandom;
    req_write[w] = ~req_write[w];
    if (drop_setup) req[w] = 1'b0;
    @(negedge pclk);
    limit = to_mode ? TIMEOUT : waits + 1;
    for (int k = 1; k <= limit; k++) begin
      chk("access_sel_en", {psel, penable} === 2'b11, 64'({psel, penable}), 64'(2'b11));
      chk("access_paddr", paddr === ea, 64'(paddr), 64'(ea));
      chk("access_pwdata", pwdata === ed, 64'(pwdata), 64'(ed));
      chk("access_pwrite", pwrite === ew, 64'(pwrite), 64'(ew));
      chk("access_done", done === '0, 64'(done), 64'(0));
      pready = !to_mode && (k == limit);
      pslverr = slverr;
      prdata = (k == limit) ? rd : DW'($urandom);
      @(negedge pclk);
    end
    pready = 1'b0;
    pslverr = 1'b0;
    if (!to_mode && !ew) exp_rdata = rd;
    exp_err = to_mode ? 1'b1 : slverr;
    chk("resp_done", done === oh, 64'(done), 64'(oh));
    chk("resp_err", err === exp_err, 64'(err), 64'(exp_err));
    chk("resp_rdata", rdata === exp_rdata, 64'(rdata), 64'(exp_rdata));
    chk("resp_sel_en", {psel, penable} === 2'b00, 64'({psel, penable}), 64'(0));
    chk("resp_gnt", gnt === oh, 64'(gnt), 64'(oh));
    req[w] = 1'b0;
    @(negedge pclk);
    chk("idle_done", done === '0, 64'(done), 64'(0));
    chk("idle_gnt", gnt === '0, 64'(gnt), 64'(0));
    chk("idle_psel", psel === 1'b0, 64'(psel), 64'(0));
  endtask

  initial begin
    bit seen;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0; prst = 1'b0;
    exp_rdata = '0; last_ptr = NREQ - 1;

    @(negedge pclk);
    @(negedge pclk);
    chk("rst_psel", psel === 1'b0, 64'(psel), 64'(0));
    chk("rst_penable", penable === 1'b0, 64'(penable), 64'(0));
    chk("rst_gnt", gnt === '0, 64'(gnt), 64'(0));
    chk("rst_done", done === '0, 64'(done), 64'(0));
    chk("rst_paddr", paddr === '0, 64'(paddr), 64'(0));
    chk("rst_pwdata", pwdata === '0, 64'(pwdata), 64'(0));
    chk("rst_pwrite", pwrite === 1'b0, 64'(pwrite), 64'(0));
    chk("rst_rdata", rdata === '0, 64'(rdata), 64'(0));
    chk("rst_err", err === 1'b0, 64'(err), 64'(0));
    prst = 1'b1;

    set_req(0, 1'b0, 32'h10, 32'h0);
    run_xfer(0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, who);
    chk("read_who", who === 0, 64'(who), 64'(0));
    chk("read_rdata", rdata === 32'hDEADBEEF, 64'(rdata), 64'(32'hDEADBEEF));
    $display("single read: who=%0d rdata=0x%0h", who, rdata);

    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'(i & 1), $urandom, $urandom);
    for (int t = 0; t < 5; t++) begin
      run_xfer(0, 1'b0, 1'b0, 1'b0, $urandom, who);
      chk("rr_order", who === (t % NREQ), 64'(who), 64'(t % NREQ));
      $display("round-robin %0d: grant=%0d", t, who);
      set_req(who, $urandom_range(0, 1), $urandom, $urandom);
    end

    req = '0;
    set_req(1, 1'b1, 32'h20, 32'h55AA);
    run_xfer(3, 1'b1, 1'b0, 1'b0, $urandom, who);
    chk("werr_who", who === 1, 64'(who), 64'(1));
    $display("wait/error write: who=%0d err=%0d rdata=0x%0h", who, err, rdata);

    set_req(2, 1'b0, $urandom, $urandom);
    set_req(3, 1'b0, $urandom, $urandom);
    run_xfer(0, 1'b0, 1'b1, 1'b0, $urandom, who);
    chk("timeout_who", who === 2, 64'(who), 64'(2));
    $display("timeout: who=%0d err=%0d", who, err);
    run_xfer(1, 1'b0, 1'b0, 1'b0, $urandom, who);
    chk("after_timeout_who", who === 3, 64'(who), 64'(3));
    $display("after timeout: who=%0d", who);

    set_req(2, 1'b1, $urandom, $urandom);
    seen = 0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge pclk);
      if (psel === 1'b1) seen = 1;
    end
    chk("midrst_setup_seen", seen === 1'b1, 64'(seen), 64'(1));
    @(negedge pclk);
    chk("midrst_in_access", penable === 1'b1, 64'(penable), 64'(1));
    prst = 1'b0;
    @(negedge pclk);
    chk("midrst_psel", psel === 1'b0, 64'(psel), 64'(0));
    chk("midrst_penable", penable === 1'b0, 64'(penable), 64'(0));
    chk("midrst_gnt", gnt === '0, 64'(gnt), 64'(0));
    chk("midrst_done", done === '0, 64'(done), 64'(0));
    chk("midrst_rdata", rdata === '0, 64'(rdata), 64'(0));
    chk("midrst_err", err === 1'b0, 64'(err), 64'(0));
    do_reset();
    set_req(3, 1'b0, $urandom, $urandom);
    set_req(0, 1'b0, $urandom, $urandom);
    run_xfer(0, 1'b0, 1'b0, 1'b0, $urandom, who);
    chk("post_rst_who", who === 0, 64'(who), 64'(0));
    $display("reset mid-access then 1001: who=%0d", who);
    req = '0;

    set_req(2, 1'b1, $urandom, $urandom);
    run_xfer(0, 1'b0, 1'b0, 1'b1, $urandom, who);
    chk("late_drop_who", who === 2, 64'(who), 64'(2));
    $display("late drop: who=%0d", who);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, 1), $urandom, $urandom);
      end
      if (req == '0) set_req(int'($urandom_range(0, NREQ - 1)), $urandom_range(0, 1), $urandom, $urandom);
      run_xfer(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1'b0,
               $urandom_range(0, 3) == 0, $urandom, who);
      $display("random %0d: grant=%0d err=%0d rdata=0x%0h", t, who, err, rdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
